// File: rtl/id_ex_hazard_reg_if.sv
// Decode-to-execute bundle: ID-side inputs, registered EX-side outputs and the
// pipeline enables / hazard status presented back to the front end.
interface id_ex_hazard_reg_if #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 16
);
  logic [5:0]        ID_opcode;
  logic [4:0]        ID_RS;
  logic [4:0]        ID_RT;
  logic [4:0]        ID_RD;
  logic              ID_USES_RT;
  logic [DATA_W-1:0] ID_RS_DATA;
  logic [DATA_W-1:0] ID_RT_DATA;
  logic [DATA_W-1:0] ID_IMM;
  logic [CTRL_W-1:0] ID_CTRL;
  logic              MEM_STALL;
  logic              FLUSH;

  logic [5:0]        EX_opcode;
  logic [4:0]        EX_RS;
  logic [4:0]        EX_RT;
  logic [4:0]        EX_RD;
  logic [DATA_W-1:0] EX_RS_DATA;
  logic [DATA_W-1:0] EX_RT_DATA;
  logic [DATA_W-1:0] EX_IMM;
  logic [CTRL_W-1:0] EX_CTRL;
  logic              ALUSrc;
  logic              PC_Write;
  logic              IFID_Write;
  logic              HAZ_STALL;
  logic [CNT_W-1:0]  BUBBLE_CNT;

  // No valid/ready pair here: the stage advances every edge unless MEM_STALL
  // freezes it; PC_Write/IFID_Write tell the front end whether it may advance.
  modport master (
    output ID_opcode, ID_RS, ID_RT, ID_RD, ID_USES_RT, ID_RS_DATA, ID_RT_DATA,
           ID_IMM, ID_CTRL, MEM_STALL, FLUSH,
    input  EX_opcode, EX_RS, EX_RT, EX_RD, EX_RS_DATA, EX_RT_DATA, EX_IMM,
           EX_CTRL, ALUSrc, PC_Write, IFID_Write, HAZ_STALL, BUBBLE_CNT
  );

  modport slave (
    input  ID_opcode, ID_RS, ID_RT, ID_RD, ID_USES_RT, ID_RS_DATA, ID_RT_DATA,
           ID_IMM, ID_CTRL, MEM_STALL, FLUSH,
    output EX_opcode, EX_RS, EX_RT, EX_RD, EX_RS_DATA, EX_RT_DATA, EX_IMM,
           EX_CTRL, ALUSrc, PC_Write, IFID_Write, HAZ_STALL, BUBBLE_CNT
  );
endinterface

// File: rtl/id_ex_hazard_reg.sv
// ID/EX pipeline register with load-use bubble insertion, memory-stall hold,
// branch flush and a saturating bubble counter.
module id_ex_hazard_reg #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 16
) (
  input logic                clk,
  input logic                rst,
  id_ex_hazard_reg_if.slave  bus
);

  logic [5:0]        ex_opcode_q;
  logic [4:0]        ex_rs_q;
  logic [4:0]        ex_rt_q;
  logic [4:0]        ex_rd_q;
  logic [DATA_W-1:0] ex_rs_data_q;
  logic [DATA_W-1:0] ex_rt_data_q;
  logic [DATA_W-1:0] ex_imm_q;
  logic [CTRL_W-1:0] ex_ctrl_q;
  logic [CNT_W-1:0]  bubble_cnt_q;

  logic load_use;
  logic hold;
  logic bubble;
  logic haz_stall;

  // EX holds a load whose destination is a live source of the ID instruction.
  assign load_use = ex_ctrl_q[1] && (ex_rt_q != 5'd0) &&
                    ((ex_rt_q == bus.ID_RS) ||
                     (bus.ID_USES_RT && (ex_rt_q == bus.ID_RT)));

  always_comb begin
    hold      = bus.MEM_STALL;
    bubble    = 1'b0;
    haz_stall = 1'b0;
    if (!bus.MEM_STALL) begin
      bubble    = bus.FLUSH || load_use;
      haz_stall = !bus.FLUSH && load_use;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_opcode_q  <= '0;
      ex_rs_q      <= '0;
      ex_rt_q      <= '0;
      ex_rd_q      <= '0;
      ex_rs_data_q <= '0;
      ex_rt_data_q <= '0;
      ex_imm_q     <= '0;
      ex_ctrl_q    <= '0;
    end else if (!hold) begin
      if (bubble) begin
        ex_opcode_q  <= '0;
        ex_rs_q      <= '0;
        ex_rt_q      <= '0;
        ex_rd_q      <= '0;
        ex_rs_data_q <= '0;
        ex_rt_data_q <= '0;
        ex_imm_q     <= '0;
        ex_ctrl_q    <= '0;
      end else begin
        ex_opcode_q  <= bus.ID_opcode;
        ex_rs_q      <= bus.ID_RS;
        ex_rt_q      <= bus.ID_RT;
        ex_rd_q      <= bus.ID_RD;
        ex_rs_data_q <= bus.ID_RS_DATA;
        ex_rt_data_q <= bus.ID_RT_DATA;
        ex_imm_q     <= bus.ID_IMM;
        ex_ctrl_q    <= bus.ID_CTRL;
      end
    end
  end

  // Saturates at all-ones so a long debug run never wraps back to a small count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_cnt_q <= '0;
    end else if (bubble && (bubble_cnt_q != {CNT_W{1'b1}})) begin
      bubble_cnt_q <= bubble_cnt_q + 1'b1;
    end
  end

  assign bus.EX_opcode  = ex_opcode_q;
  assign bus.EX_RS      = ex_rs_q;
  assign bus.EX_RT      = ex_rt_q;
  assign bus.EX_RD      = ex_rd_q;
  assign bus.EX_RS_DATA = ex_rs_data_q;
  assign bus.EX_RT_DATA = ex_rt_data_q;
  assign bus.EX_IMM     = ex_imm_q;
  assign bus.EX_CTRL    = ex_ctrl_q;
  assign bus.ALUSrc     = ex_ctrl_q[4];
  assign bus.BUBBLE_CNT = bubble_cnt_q;
  assign bus.HAZ_STALL  = haz_stall;
  assign bus.PC_Write   = !rst && !hold && !haz_stall;
  assign bus.IFID_Write = !rst && !hold && !haz_stall;

endmodule

// File: tb/tb_id_ex_hazard_reg.sv
// Directed bench for id_ex_hazard_reg: reset, capture, load-use bubbles,
// memory-stall hold, flush priority and counter saturation.
module tb_id_ex_hazard_reg;

  logic clk;
  logic rst;
  int   n_total;
  int   n_bad;

  id_ex_hazard_reg_if #(.DATA_W(32), .CTRL_W(8), .CNT_W(16)) bus ();
  id_ex_hazard_reg_if #(.DATA_W(32), .CTRL_W(8), .CNT_W(2))  bus2 ();

  id_ex_hazard_reg #(.DATA_W(32), .CTRL_W(8), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  id_ex_hazard_reg #(.DATA_W(32), .CTRL_W(8), .CNT_W(2)) dut_sat (
    .clk (clk),
    .rst (rst),
    .bus (bus2.slave)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: run did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic uses_rt, input logic [31:0] rs_data,
                       input logic [31:0] rt_data, input logic [31:0] imm,
                       input logic [7:0] ctrl);
    bus.ID_opcode  = op;
    bus.ID_RS      = rs;
    bus.ID_RT      = rt;
    bus.ID_RD      = rd;
    bus.ID_USES_RT = uses_rt;
    bus.ID_RS_DATA = rs_data;
    bus.ID_RT_DATA = rt_data;
    bus.ID_IMM     = imm;
    bus.ID_CTRL    = ctrl;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk_enables(input string tag, input logic pc, input logic haz);
    #1;
    chk({tag, "_pc"},   32'(bus.PC_Write),   32'(pc));
    chk({tag, "_ifid"}, 32'(bus.IFID_Write), 32'(pc));
    chk({tag, "_haz"},  32'(bus.HAZ_STALL),  32'(haz));
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    rst     = 1'b0;
    drive(6'h00, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0, 32'h0, 32'h0, 8'h00);
    bus.MEM_STALL  = 1'b0;
    bus.FLUSH      = 1'b0;
    bus2.ID_opcode = '0; bus2.ID_RS = '0; bus2.ID_RT = '0; bus2.ID_RD = '0;
    bus2.ID_USES_RT = 1'b0; bus2.ID_RS_DATA = '0; bus2.ID_RT_DATA = '0;
    bus2.ID_IMM = '0; bus2.ID_CTRL = '0; bus2.MEM_STALL = 1'b0; bus2.FLUSH = 1'b0;

    // async reset before any clock edge
    #2 rst = 1'b1;
    #1;
    chk("rst_ctrl",  32'(bus.EX_CTRL),    0);
    chk("rst_rs",    32'(bus.EX_RS),      0);
    chk("rst_cnt",   32'(bus.BUBBLE_CNT), 0);
    chk("rst_pc",    32'(bus.PC_Write),   0);
    chk("rst_ifid",  32'(bus.IFID_Write), 0);
    tick();
    rst = 1'b0;

    // normal capture
    drive(6'h08, 5'd2, 5'd3, 5'd4, 1'b0, 32'h0A, 32'h0B, 32'h0C, 8'h11);
    chk_enables("norm", 1'b1, 1'b0);
    tick();
    chk("norm_rs",     32'(bus.EX_RS),      2);
    chk("norm_rt",     32'(bus.EX_RT),      3);
    chk("norm_rsdata", bus.EX_RS_DATA,      32'h0A);
    chk("norm_imm",    bus.EX_IMM,          32'h0C);
    chk("norm_alusrc", 32'(bus.ALUSrc),     1);
    chk("norm_op",     32'(bus.EX_opcode),  32'h08);

    // load-use via RS: lw $2 then add using $2
    drive(6'h23, 5'd1, 5'd2, 5'd0, 1'b0, 32'h100, 32'h0, 32'h4, 8'h1B);
    tick();
    chk("lw_ctrl", 32'(bus.EX_CTRL), 32'h1B);
    drive(6'h00, 5'd2, 5'd5, 5'd6, 1'b1, 32'h22, 32'h55, 32'h0, 8'h21);
    chk_enables("lu_rs", 1'b0, 1'b1);
    tick();
    chk("lu_bub_ctrl", 32'(bus.EX_CTRL),    0);
    chk("lu_bub_rs",   32'(bus.EX_RS),      0);
    chk("lu_bub_cnt",  32'(bus.BUBBLE_CNT), 1);
    chk_enables("lu_after", 1'b1, 1'b0);
    tick();
    chk("lu_cap_rs",   32'(bus.EX_RS),      2);
    chk("lu_cap_rd",   32'(bus.EX_RD),      6);
    chk("lu_cap_ctrl", 32'(bus.EX_CTRL),    32'h21);
    chk("lu_cap_cnt",  32'(bus.BUBBLE_CNT), 1);

    // case A: load to $0 never stalls
    drive(6'h23, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0, 32'h0, 32'h8, 8'h1B);
    tick();
    drive(6'h00, 5'd0, 5'd0, 5'd7, 1'b1, 32'h0, 32'h0, 32'h0, 8'h21);
    chk_enables("zero", 1'b1, 1'b0);
    tick();
    chk("zero_ctrl", 32'(bus.EX_CTRL),    32'h21);
    chk("zero_cnt",  32'(bus.BUBBLE_CNT), 1);

    // case B: RT match ignored when RT is not a source
    drive(6'h23, 5'd1, 5'd3, 5'd0, 1'b0, 32'h0, 32'h0, 32'h8, 8'h1B);
    tick();
    drive(6'h08, 5'd7, 5'd3, 5'd0, 1'b0, 32'h7, 32'h0, 32'h1, 8'h13);
    chk_enables("nort", 1'b1, 1'b0);
    tick();
    chk("nort_ctrl", 32'(bus.EX_CTRL),    32'h13);
    chk("nort_cnt",  32'(bus.BUBBLE_CNT), 1);

    // RT match that is a real source does stall
    drive(6'h23, 5'd1, 5'd3, 5'd0, 1'b0, 32'h0, 32'h0, 32'h8, 8'h1B);
    tick();
    drive(6'h00, 5'd8, 5'd3, 5'd9, 1'b1, 32'h8, 32'h3, 32'h0, 8'h21);
    chk_enables("lu_rt", 1'b0, 1'b1);
    tick();
    chk("lu_rt_ctrl", 32'(bus.EX_CTRL),    0);
    chk("lu_rt_cnt",  32'(bus.BUBBLE_CNT), 2);
    tick();
    chk("lu_rt_cap", 32'(bus.EX_RT), 3);

    // FLUSH beats load-use and keeps the PC moving
    drive(6'h23, 5'd1, 5'd4, 5'd0, 1'b0, 32'h0, 32'h0, 32'h8, 8'h1B);
    tick();
    drive(6'h00, 5'd4, 5'd5, 5'd10, 1'b1, 32'h4, 32'h5, 32'h0, 8'h21);
    bus.FLUSH = 1'b1;
    chk_enables("flu", 1'b1, 1'b0);
    tick();
    bus.FLUSH = 1'b0;
    chk("flu_ctrl", 32'(bus.EX_CTRL),    0);
    chk("flu_cnt",  32'(bus.BUBBLE_CNT), 3);
    tick();
    chk("flu_cap_rs", 32'(bus.EX_RS), 4);

    // MEM_STALL holds for 3 cycles, also masking a FLUSH on the last one
    bus.MEM_STALL = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(6'h2B, 5'(10 + i), 5'(20 + i), 5'd1, 1'b1, 32'(i), 32'h0, 32'h0, 8'h1B);
      bus.FLUSH = (i == 2);
      chk_enables("ms", 1'b0, 1'b0);
      tick();
      chk("ms_rs",   32'(bus.EX_RS),      4);
      chk("ms_ctrl", 32'(bus.EX_CTRL),    32'h21);
      chk("ms_cnt",  32'(bus.BUBBLE_CNT), 3);
    end
    bus.MEM_STALL = 1'b0;
    bus.FLUSH     = 1'b1;
    chk_enables("ms_flush", 1'b1, 1'b0);
    tick();
    bus.FLUSH = 1'b0;
    chk("ms_fl_ctrl", 32'(bus.EX_CTRL),    0);
    chk("ms_fl_rs",   32'(bus.EX_RS),      0);
    chk("ms_fl_cnt",  32'(bus.BUBBLE_CNT), 4);

    // async reset mid-stall with EX_CTRL=FF loaded
    drive(6'h3F, 5'd9, 5'd5, 5'd1, 1'b0, 32'hDEAD, 32'hBEEF, 32'h1, 8'hFF);
    tick();
    chk("ff_ctrl", 32'(bus.EX_CTRL), 32'hFF);
    drive(6'h00, 5'd5, 5'd6, 5'd7, 1'b1, 32'h5, 32'h6, 32'h0, 8'h21);
    chk_enables("ff_lu", 1'b0, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("mrst_ctrl",   32'(bus.EX_CTRL),    0);
    chk("mrst_alusrc", 32'(bus.ALUSrc),     0);
    chk("mrst_data",   bus.EX_RS_DATA,      0);
    chk("mrst_cnt",    32'(bus.BUBBLE_CNT), 0);
    chk("mrst_pc",     32'(bus.PC_Write),   0);
    chk("mrst_haz",    32'(bus.HAZ_STALL),  0);
    tick();
    rst = 1'b0;
    chk_enables("post_rst", 1'b1, 1'b0);
    tick();
    chk("post_rst_rs", 32'(bus.EX_RS), 5);

    // saturation on the 2-bit counter instance
    bus2.FLUSH = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("sat_cnt", 32'(bus2.BUBBLE_CNT), (i < 3) ? 32'(i + 1) : 32'd3);
    end
    bus2.FLUSH = 1'b0;
    tick();
    chk("sat_hold", 32'(bus2.BUBBLE_CNT), 3);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
